// File: rtl/aftab_bsu_scheduler_if.sv
// Signal bundle between the two BSU requesters, the shared aftab_BSU and the scheduler.
// The slave modport is the scheduler's view; master is the requester/BSU side.
interface aftab_bsu_scheduler_if #(
  parameter int size = 32
);
  logic            req0;
  logic            req1;
  logic [size-1:0] dataIn0;
  logic [size-1:0] dataIn1;
  logic [4:0]      shiftAmount0;
  logic [4:0]      shiftAmount1;
  logic [1:0]      selShift0;
  logic [1:0]      selShift1;
  logic            grant0;
  logic            grant1;
  logic            respValid0;
  logic            respValid1;
  logic            respAck0;
  logic            respAck1;
  logic [size-1:0] respData;
  logic [size-1:0] bsuDataIn;
  logic [4:0]      bsuShiftAmount;
  logic [1:0]      bsuSelShift;
  logic [size-1:0] bsuDataOut;
  logic            busy;

  modport slave (
    input  req0, req1, dataIn0, dataIn1, shiftAmount0, shiftAmount1,
           selShift0, selShift1, respAck0, respAck1, bsuDataOut,
    output grant0, grant1, respValid0, respValid1, respData,
           bsuDataIn, bsuShiftAmount, bsuSelShift, busy
  );

  modport master (
    output req0, req1, dataIn0, dataIn1, shiftAmount0, shiftAmount1,
           selShift0, selShift1, respAck0, respAck1, bsuDataOut,
    input  grant0, grant1, respValid0, respValid1, respData,
           bsuDataIn, bsuShiftAmount, bsuSelShift, busy
  );
endinterface

// File: rtl/aftab_bsu_scheduler.sv
// Round-robin sharing of one aftab_BSU between the EXE stage (port 0) and the
// mul/div normalisation unit (port 1); registered operands, valid/ack result return.
module aftab_bsu_scheduler #(
  parameter int size = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  aftab_bsu_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [size-1:0] data_q, data_d;
  logic [4:0]      amt_q, amt_d;
  logic [1:0]      sel_q, sel_d;
  logic [size-1:0] resp_data_q, resp_data_d;
  logic            gnt0, gnt1;
  logic            owner_ack;

  // Arbitration: on a tie the port that did not win last time goes first.
  // Gating with rst keeps the grants low while reset is held.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst && state_q == IDLE) begin
      if (bus.req0 && bus.req1) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  assign owner_ack = owner_q ? bus.respAck1 : bus.respAck0;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and datapath next-value logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    data_d       = data_q;
    amt_d        = amt_q;
    sel_d        = sel_q;
    resp_data_d  = resp_data_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_d      = ISSUE;
          owner_d      = gnt1;
          last_grant_d = gnt1;
          data_d       = gnt1 ? bus.dataIn1      : bus.dataIn0;
          amt_d        = gnt1 ? bus.shiftAmount1 : bus.shiftAmount0;
          sel_d        = gnt1 ? bus.selShift1    : bus.selShift0;
        end
      end
      ISSUE: begin
        resp_data_d = bus.bsuDataOut;
        state_d     = RESP;
      end
      RESP: begin
        if (owner_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: operand and result registers are reset so the BSU sees zeros, not X, after reset.
    if (!rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      data_q       <= '0;
      amt_q        <= '0;
      sel_q        <= '0;
      resp_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      data_q       <= data_d;
      amt_q        <= amt_d;
      sel_q        <= sel_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Output logic
  always_comb begin
    bus.grant0         = gnt0;
    bus.grant1         = gnt1;
    bus.respValid0     = (state_q == RESP) && !owner_q;
    bus.respValid1     = (state_q == RESP) &&  owner_q;
    bus.busy           = (state_q != IDLE);
    bus.respData       = resp_data_q;
    bus.bsuDataIn      = data_q;
    bus.bsuShiftAmount = amt_q;
    bus.bsuSelShift    = sel_q;
  end

endmodule

// File: doc/aftab_bsu_scheduler.md
Name: aftab_bsu_scheduler

Overview:
- Shares one aftab_BSU barrel shifter between two requesters: port 0 is the core EXE stage, port 1 is the multiply/divide normalisation unit.
- Arbitrates with round-robin priority and registers the winning operands to drive the BSU.
- Captures the BSU result and returns it through a valid/ack handshake to the requester that was granted.
- Sits in the datapath between the requesters and the BSU instance.

Parameters:
- size, 32, data width of operands and results; must match the BSU `size`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0, req1  input  1 each  shift request from requester 0 / 1.
- dataIn0, dataIn1  input  size each  operand to shift.
- shiftAmount0, shiftAmount1  input  5 each  shift distance.
- selShift0, selShift1  input  2 each  shift type: 00 SLL, 10 SRL, 11 SRA, 01 reserved.
- grant0, grant1  output  1 each  combinational one-cycle accept pulse.
- respValid0, respValid1  output  1 each  result available for requester 0 / 1.
- respAck0, respAck1  input  1 each  requester consumed the result.
- respData  output  size  shared result bus.
- bsuDataIn  output  size  to BSU dataIn.
- bsuShiftAmount  output  5  to BSU shiftAmount.
- bsuSelShift  output  2  to BSU selShift.
- bsuDataOut  input  size  from BSU dataOut.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; lastGrant goes to 1, so requester 0 wins the first tie.
  - Operand registers, respData and owner register all clear to 0.
  - respValid0/1=0, busy=0; grants are 0 while reset is active.
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - If only one req is high, that port is granted.
  - If both are high, the port that is not lastGrant is granted.
  - If neither is high, nothing is granted.
  - grantX=1 combinationally in IDLE only.
  - On the granting edge: latch dataInX, shiftAmountX and selShiftX into the operand registers; set owner=X and lastGrant=X; go to ISSUE.
- Requester rules:
  - A requester holds reqX and its operands stable until it sees grantX.
  - Operands are sampled only on the grant cycle.
  - A requester drops reqX after the grant unless it wants another operation.
- ISSUE (exactly one cycle):
  - bsu* outputs show the operand registers.
  - At the end of the cycle, bsuDataOut is captured into respData; go to RESP.
- RESP:
  - respValid[owner]=1 and the other respValid stays 0; respData is stable.
  - Stay in RESP until respAck[owner]=1, then go to IDLE on that edge.
  - respAck of the non-owner port is ignored.
  - No grant is issued while in RESP, even if the ack arrives in the same cycle.
- Latency and throughput:
  - Grant in cycle N → respValid high in cycle N+2.
  - Minimum issue-to-issue interval is 3 cycles (ack in N+2, IDLE in N+3, next grant in N+3).
- bsu* outputs hold the operand-register values in every state; they are 0 after reset.
- selShift=01 is forwarded unchanged; the BSU returns 0 and the scheduler returns respData=0 with the normal handshake.
- shiftAmount is used modulo 32 because the port is 5 bits wide. A shift of 0 returns the operand unchanged for 00, 10 and 11.
- busy=1 in ISSUE and RESP.
- Reset asserted mid-operation: the in-flight result is discarded and no respValid is produced after reset releases. Requesters must re-request.

Test Plan:
- Reset, then only req0 with dataIn0=0x0000_00F0, amt=4, sel=00 → grant0 in cycle 0, respValid0 in cycle 2, respData=0x0000_0F00; respValid1 stays 0.
- SRA on requester 1: dataIn1=0x8000_0000, amt=31, sel=11 → respData=0xFFFF_FFFF. Then SRL with the same operand and sel=10 → 0x0000_0001.
- Tie after reset: req0 and req1 both high and held → grant order 0,1,0,1. Each grant comes only after the previous respAck. No double grant, and no grant in RESP.
- Ack protocol: respAck1 pulsed while owner=0 → ignored; respValid0 stays high and respData is unchanged. Hold respAck0 low for 5 cycles → FSM stays in RESP and busy=1.
- Reserved sel=01 on port 0, dataIn=0xFFFF_FFFF, amt=3 → respData=0 with the normal 2-cycle handshake.
- Drop rst low during ISSUE → all outputs are 0 immediately, without waiting for a clock edge. After release, no respValid appears, and a fresh req0 is granted first.
